// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: WS2812 frame sequencer and NRZ serialiser.
// Fetches LED_NUM 24-bit {G,R,B} words and streams them on dout.
// Ports: sys_clk, sys_rst_n (async, active-low), ws2812_start (frame
//   request), cfg_data (current word), cfg_start (word latched / advance),
//   dout (DIN line), busy (frame in progress), frame_done (end of gap).
// Option: define WS2812_INV_EN for an inverted dout (idle level 1).
module ws2812_frame_ctrl #(
  parameter int LED_NUM    = 64,
  parameter int BIT_CLKS   = 62,
  parameter int T0H_CLKS   = 20,
  parameter int T1H_CLKS   = 40,
  parameter int RESET_CLKS = 15000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        ws2812_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_start,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int LW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int RW = (RESET_CLKS > 1) ? $clog2(RESET_CLKS) : 1;

  localparam logic [CW-1:0] CLK_LAST = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] T0H_C    = CW'(T0H_CLKS);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H_CLKS);
  localparam logic [LW-1:0] LED_LAST = LW'(LED_NUM - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CLKS - 1);

`ifdef WS2812_INV_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_RESET = 2'd3;

  logic [1:0]    state;
  logic [23:0]   shift_reg;
  logic [CW-1:0] clk_cnt;
  logic [4:0]    bit_cnt;
  logic [LW-1:0] led_cnt;
  logic [RW-1:0] rst_cnt;
  logic          pending;

  logic [CW-1:0] hi_thr;
  logic          bit_hi;
  logic          last_clk;
  logic          last_bit;
  logic          last_led;
  logic          last_rst;

  assign hi_thr   = shift_reg[23] ? T1H_C : T0H_C;
  assign bit_hi   = (clk_cnt < hi_thr);
  assign last_clk = (clk_cnt == CLK_LAST);
  assign last_bit = (bit_cnt == 5'd23);
  assign last_led = (led_cnt == LED_LAST);
  assign last_rst = (rst_cnt == RST_LAST);

  assign busy = (state != S_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      led_cnt    <= '0;
      rst_cnt    <= '0;
      pending    <= 1'b0;
      cfg_start  <= 1'b0;
      frame_done <= 1'b0;
      dout       <= IDLE_LVL;
    end else begin
      cfg_start  <= 1'b0;
      frame_done <= 1'b0;
      // Requests while busy collapse into one follow-up frame.
      if (ws2812_start && state != S_IDLE)
        pending <= 1'b1;
      case (state)
        S_IDLE: begin
          dout <= IDLE_LVL;
          if (ws2812_start)
            state <= S_LOAD;
        end
        S_LOAD: begin
          dout      <= IDLE_LVL;
          shift_reg <= cfg_data;
          led_cnt   <= '0;
          bit_cnt   <= '0;
          clk_cnt   <= '0;
          cfg_start <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          dout <= bit_hi ^ IDLE_LVL;
          if (last_clk) begin
            clk_cnt <= '0;
            if (last_bit) begin
              bit_cnt <= '0;
              if (last_led) begin
                state   <= S_RESET;
                rst_cnt <= '0;
              end else begin
                // Next word loads seamlessly to keep the bit period exact.
                shift_reg <= cfg_data;
                cfg_start <= 1'b1;
                led_cnt   <= led_cnt + 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 5'd1;
              shift_reg <= {shift_reg[22:0], 1'b0};
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_RESET: begin
          dout <= IDLE_LVL;
          if (last_rst) begin
            frame_done <= 1'b1;
            rst_cnt    <= '0;
            if (pending || ws2812_start) begin
              state   <= S_LOAD;
              pending <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb_ws2812_frame_ctrl: scoreboard bench for ws2812_frame_ctrl.
// Scaled-down timing parameters keep whole frames short.
`timescale 1ns/1ps
module tb_ws2812_frame_ctrl;

  localparam int LED_NUM  = 4;
  localparam int BIT_CLKS = 12;
  localparam int T0H      = 3;
  localparam int T1H      = 7;
  localparam int RST_CLKS = 40;
  localparam int SEND_LEN = LED_NUM * 24 * BIT_CLKS;
  localparam int FRM_MAX  = SEND_LEN + RST_CLKS + 200;

`ifdef WS2812_INV_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  logic        ws2812_start;
  logic [23:0] cfg_data;
  logic        cfg_start;
  logic        dout;
  logic        busy;
  logic        frame_done;

  ws2812_frame_ctrl #(
    .LED_NUM   (LED_NUM),
    .BIT_CLKS  (BIT_CLKS),
    .T0H_CLKS  (T0H),
    .T1H_CLKS  (T1H),
    .RESET_CLKS(RST_CLKS)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .ws2812_start(ws2812_start),
    .cfg_data    (cfg_data),
    .cfg_start   (cfg_start),
    .dout        (dout),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Config block model: word table plus index advanced by cfg_start.
  logic [23:0] mem [LED_NUM];
  int          cfg_idx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      cfg_idx <= 0;
    else if (cfg_start)
      cfg_idx <= (cfg_idx == LED_NUM - 1) ? 0 : cfg_idx + 1;
  end

  assign cfg_data = mem[cfg_idx];

  int exp_hi[$];
  int exp_frm[$];
  int n_chk;
  int n_pass;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req)
      n_pass++;
    else
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: pops expected bit high-times and frame records.
  int cyc;
  int rise_t;
  int last_rise;
  int bits_seen;
  int cs_cnt;
  int send_t;
  int last_cs;
  int frames_done;
  logic prev_lvl;

  initial begin
    logic lvl;
    cyc = 0;
    prev_lvl = 1'b0;
    bits_seen = 0;
    cs_cnt = 0;
    frames_done = 0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!sys_rst_n) begin
        prev_lvl = 1'b0;
        bits_seen = 0;
        cs_cnt = 0;
      end else begin
        lvl = dout ^ INV;
        if (lvl && !prev_lvl) begin
          if (bits_seen > 0)
            chk("bit_period", cyc - last_rise, BIT_CLKS);
          last_rise = cyc;
          rise_t = cyc;
          bits_seen++;
        end
        if (!lvl && prev_lvl) begin
          if (exp_hi.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_pulse: high %0d clk, none expected",
                     cyc - rise_t);
          end else begin
            chk("bit_high", cyc - rise_t, exp_hi.pop_front());
          end
        end
        prev_lvl = lvl;
        if (cfg_start) begin
          if (cs_cnt == 0)
            send_t = cyc;
          else
            chk("cfg_start_gap", cyc - last_cs, 24 * BIT_CLKS);
          last_cs = cyc;
          cs_cnt++;
        end
        if (frame_done) begin
          if (exp_frm.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_frame: got frame_done, want none");
          end else begin
            void'(exp_frm.pop_front());
            chk("frame_cfg_starts", cs_cnt, LED_NUM);
            chk("frame_done_time", cyc - send_t, SEND_LEN + RST_CLKS);
          end
          cs_cnt = 0;
          bits_seen = 0;
          frames_done++;
        end
      end
    end
  end

  task automatic push_frame();
    for (int l = 0; l < LED_NUM; l++)
      for (int b = 23; b >= 0; b--)
        exp_hi.push_back(mem[l][b] ? T1H : T0H);
    exp_frm.push_back(1);
  endtask

  task automatic fill_const(input logic [23:0] w);
    for (int l = 0; l < LED_NUM; l++)
      mem[l] = w;
  endtask

  task automatic fill_rand();
    for (int l = 0; l < LED_NUM; l++)
      mem[l] = 24'($urandom);
  endtask

  task automatic pulse_raw();
    @(posedge sys_clk);
    #1 ws2812_start = 1'b1;
    @(posedge sys_clk);
    #1 ws2812_start = 1'b0;
  endtask

  // From IDLE the request must be seen as LOAD one cycle later.
  task automatic pulse_start();
    @(posedge sys_clk);
    #1 ws2812_start = 1'b1;
    @(posedge sys_clk);
    #1 chk("busy_after_start", busy, 1);
    ws2812_start = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (frames_done < n && k < FRM_MAX * 2) begin
      @(posedge sys_clk);
      k++;
    end
    if (frames_done < n) begin
      n_chk++;
      $display("FAIL frame_timeout: got %0d frames, want %0d", frames_done, n);
    end
  endtask

  task automatic wait_cs(input int n);
    int k;
    k = 0;
    while (cs_cnt < n && k < FRM_MAX) begin
      @(posedge sys_clk);
      k++;
    end
    if (cs_cnt < n) begin
      n_chk++;
      $display("FAIL cfg_start_timeout: got %0d, want %0d", cs_cnt, n);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    ws2812_start = 1'b0;
    fill_const(24'h0);
    n_chk = 0;
    n_pass = 0;
    #23;
    chk("rst_dout", dout, INV);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_start", cfg_start, 0);
    chk("rst_frame_done", frame_done, 0);
    #4 sys_rst_n = 1'b1;

    fill_const(24'h00_07_00);
    push_frame();
    pulse_start();
    wait_frames(1);
    #1 chk("idle_after_f1", busy, 0);
    chk("idle_level_f1", dout, INV);

    fill_const(24'hFFFFFF);
    push_frame();
    pulse_start();
    wait_frames(2);
    #1 chk("idle_after_f2", busy, 0);

    fill_rand();
    push_frame();
    push_frame();
    pulse_start();
    wait_cs(LED_NUM);
    pulse_raw();
    wait_frames(3);
    #1 chk("busy_chained", busy, 1);
    wait_frames(4);
    #1 chk("idle_after_f4", busy, 0);

    fill_rand();
    push_frame();
    push_frame();
    pulse_start();
    wait_cs(2);
    for (int i = 0; i < 3; i++) begin
      repeat (3 + $urandom_range(0, 20)) @(posedge sys_clk);
      pulse_raw();
    end
    wait_frames(5);
    #1 chk("busy_pending", busy, 1);
    wait_frames(6);
    #1 chk("idle_after_f6", busy, 0);
    repeat (RST_CLKS + 4 * BIT_CLKS) @(posedge sys_clk);
    chk("collapsed_frames", frames_done, 6);

    fill_rand();
    push_frame();
    pulse_start();
    wait_cs(3);
    repeat (5 * BIT_CLKS) @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1 chk("midrst_dout", dout, INV);
    chk("midrst_busy", busy, 0);
    chk("midrst_cfg_start", cfg_start, 0);
    exp_hi.delete();
    exp_frm.delete();
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;

    fill_rand();
    push_frame();
    pulse_start();
    wait_frames(7);

    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(1, 30)) @(posedge sys_clk);
      fill_rand();
      push_frame();
      pulse_start();
      wait_frames(8 + f);
    end

    repeat (20) @(posedge sys_clk);
    #1 chk("bits_left", exp_hi.size(), 0);
    chk("frames_left", exp_frm.size(), 0);
    chk("final_idle_dout", dout, INV);
    chk("final_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
